ddr_memtest_engine: RTL and testbench
=====================================

Name: ddr_memtest_engine

Overview:
- Parametrised DRAM self-test master: after controller init, writes a pattern-generated region over the Wishbone-classic user port, reads it back, compares every word.
- Successor to the single-word A5/AABB bring-up tester: configurable region size, 4 pattern modes, error counting, first-fail capture, ack timeout.
- Sits in the board top, between the DRAM wrapper's user port and the LEDs/debug.

Parameters:
- WORD_SIZE, 256, data width of one transfer (multiple of 32).
- ADDR_WIDTH, 25, word-address width.
- ADDR_SHIFT, 7, left shift applied to the word address to form addr_o.
- NUM_WORDS, 1024, words tested per run (>=1).
- START_WORD, 0, first word address.
- DELAY_CYCLES, 100_000_000, settle cycles after initialized; 0 skips the delay.
- TIMEOUT_CYCLES, 1_000_000, max cycles waiting for ack_i; 0 disables.
- ERR_CNT_WIDTH, 16, error counter width.
- PATTERN, {16{16'hAABB}}, base data pattern (WORD_SIZE bits).

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle run request.
- mode  in  2  pattern mode, sampled on accepted start.
- initialized  in  1  DRAM controller calibration done.
- cyc_o, stb_o, we_o  out  1 each  bus cycle / strobe / write-enable.
- addr_o  out  32  byte address = ((START_WORD+idx) mod 2^ADDR_WIDTH) << ADDR_SHIFT, truncated to 32 bits.
- data_o  out  WORD_SIZE  write data.
- data_i  in  WORD_SIZE  read data.
- ack_i  in  1  transfer acknowledge.
- busy, done, pass, fail, timeout  out  1 each  status.
- err_count  out  ERR_CNT_WIDTH  mismatching words, saturating.
- first_fail_addr  out  ADDR_WIDTH  word address of first mismatch.

Behaviour:
- Reset: all outputs 0; state IDLE; idx 0.
- States: IDLE, WAIT_INIT, DELAY, WRITE, WAIT_WRITE, READ, WAIT_READ, CHECK, DONE.
- start accepted only in IDLE or DONE; ignored otherwise. Acceptance clears done/pass/fail/timeout/err_count/first_fail_addr, latches mode, sets busy, goes to WAIT_INIT.
- WAIT_INIT -> DELAY when initialized=1. DELAY counts DELAY_CYCLES, then goes to WRITE with idx=0.
- WRITE: drive cyc/stb/we=1, addr_o, data_o=pat(idx). Go to WAIT_WRITE.
- WAIT_WRITE: hold outputs stable until ack_i. On ack, deassert cyc/stb/we in the next cycle. If idx==NUM_WORDS-1, go to READ with idx=0; else go to WRITE with idx+1.
- Bus gap: cyc is low for at least one cycle between transfers. A write costs ≥3 cycles.
- READ: cyc/stb=1, we=0. Go to WAIT_READ.
- WAIT_READ: on ack, capture data_i into a register, deassert, go to CHECK.
- CHECK: one cycle. Compare the captured word against pat(idx).
  - On mismatch: err_count+1, saturating at all-ones.
  - On the first mismatch: load first_fail_addr.
  - Next state: READ with idx+1, or DONE after the last word.
- Timeout: in WAIT_* a counter runs (reset on each state entry). On reaching TIMEOUT_CYCLES with no ack:
  - deassert cyc/stb/we;
  - set timeout and fail;
  - go to DONE.
  - If ack_i and timeout occur in the same cycle, ack wins.
- DONE: busy=0, done=1, pass=(err_count==0 && !timeout), fail=!pass. Held until the next start or rst.
- Patterns pat(a), where a = word address:
  - mode 0: PATTERN.
  - mode 1: PATTERN if a even, ~PATTERN if odd.
  - mode 2: {a zero-extended to 32}, replicated WORD_SIZE/32 times.
  - mode 3: walking one, only bit (a mod WORD_SIZE) set.
- Address wrap: START_WORD+idx wraps modulo 2^ADDR_WIDTH.
- rst mid-transfer: immediate return to reset values, bus released in the same cycle.

Optional Feature:
- MEMTEST_LOOP_EN defined:
  - After CHECK of the last word, if err_count==0 and no timeout, restart at WRITE (skipping DELAY) instead of DONE.
  - Adds output loop_count (32 bits): completed clean passes, wraps.
  - start in this mode stops the run at the next CHECK and goes to DONE.
  - Any error ends the run in DONE.
- Undefined: single pass; no loop_count port.

Decomposition:
- Package memtest_pkg: state enum memtest_state_t, mode enum memtest_mode_t (PAT_FIXED, PAT_ALT, PAT_ADDR, PAT_WALK).
- Sub-module memtest_pattern_gen: combinational, takes WORD_SIZE, ADDR_WIDTH, PATTERN, mode, addr, produces the word. Shared by the write and compare paths.

Test Plan:
- Bench slave model: RAM with ack 1 cycle after stb. NUM_WORDS=8, DELAY_CYCLES=4, mode 0, start → 8 writes then 8 reads, addr_o steps by 128; done=1, pass=1, err_count=0.
- Slave corrupts bit 3 of the read data at words 2 and 5, mode 2 → err_count=2, first_fail_addr=2, fail=1.
- Slave never acks, TIMEOUT_CYCLES=16 → cyc_o drops 16 cycles after stb_o rises; timeout=1, fail=1, done=1.
- initialized held low 50 cycles after start → no cyc_o until initialized rises plus 4 delay cycles.
- START_WORD=2^25-2, NUM_WORDS=4 → word addresses 0x1FFFFFE, 0x1FFFFFF, 0, 1; mode 3 data bit index equals word address mod 256.
- rst asserted during WAIT_WRITE → cyc_o/stb_o=0 on the next edge; a fresh start completes with pass.

Source files
------------

// File: rtl/memtest_pkg.sv
// -----------------------------------------------------------------------------
// memtest_pkg
//   Shared types for the DRAM self-test engine.
//   - memtest_state_t : sequencer states of ddr_memtest_engine
//   - memtest_mode_t  : data pattern selector used by memtest_pattern_gen
// -----------------------------------------------------------------------------
package memtest_pkg;

  // Width of one pattern lane; the address pattern replicates one lane.
  localparam int LANE_W = 32;

  // Wishbone byte-address width.
  localparam int BUS_ADDR_W = 32;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_WAIT_INIT  = 4'd1,
    S_DELAY      = 4'd2,
    S_WRITE      = 4'd3,
    S_WAIT_WRITE = 4'd4,
    S_READ       = 4'd5,
    S_WAIT_READ  = 4'd6,
    S_CHECK      = 4'd7,
    S_DONE       = 4'd8
  } memtest_state_t;

  typedef enum logic [1:0] {
    PAT_FIXED = 2'd0,  // base pattern every word
    PAT_ALT   = 2'd1,  // base pattern on even words, inverted on odd words
    PAT_ADDR  = 2'd2,  // word address replicated in every 32-bit lane
    PAT_WALK  = 2'd3   // single one at bit (address mod word size)
  } memtest_mode_t;

endpackage

// File: rtl/memtest_pattern_gen.sv
// -----------------------------------------------------------------------------
// memtest_pattern_gen
//   Purely combinational test-data generator. The same instance feeds both the
//   write data path and the read-back comparator, so written and expected words
//   can never disagree by construction.
//
// Ports:
//   mode_i  in   memtest_mode_t   pattern selector
//   addr_i  in   ADDR_WIDTH       word address the pattern is generated for
//   word_o  out  WORD_SIZE        generated data word
// -----------------------------------------------------------------------------
module memtest_pattern_gen
  import memtest_pkg::*;
#(
  parameter int                   WORD_SIZE  = 256,
  parameter int                   ADDR_WIDTH = 25,
  parameter logic [WORD_SIZE-1:0] PATTERN    = {16{16'hAABB}}
) (
  input  memtest_mode_t          mode_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  output logic [WORD_SIZE-1:0]   word_o
);

  localparam int                   NUM_LANES = WORD_SIZE / LANE_W;
  localparam logic [WORD_SIZE-1:0] ONE_HOT0  = {{(WORD_SIZE-1){1'b0}}, 1'b1};
  localparam logic [31:0]          WS_U      = 32'(WORD_SIZE);

  logic [LANE_W-1:0] lane_w;
  logic [31:0]       walk_pos_w;

  assign lane_w     = LANE_W'(addr_i);
  // Word size need not be a power of two, so use a true modulo for the bit index.
  assign walk_pos_w = 32'(addr_i) % WS_U;

  // NOTE: every output of a combinational block gets a default assignment
  // first, so no path through the case can leave it unassigned (no latch).
  always_comb begin
    word_o = PATTERN;
    unique case (mode_i)
      PAT_FIXED: word_o = PATTERN;
      PAT_ALT:   word_o = addr_i[0] ? ~PATTERN : PATTERN;
      PAT_ADDR:  word_o = {NUM_LANES{lane_w}};
      PAT_WALK:  word_o = ONE_HOT0 << walk_pos_w;
    endcase
  end

endmodule

// File: rtl/ddr_memtest_engine.sv
// -----------------------------------------------------------------------------
// ddr_memtest_engine
//   DRAM self-test master on a Wishbone-classic user port. After the controller
//   reports calibration and a settle delay, it writes NUM_WORDS pattern words
//   starting at START_WORD, reads them back and compares each word, counting
//   mismatches and capturing the first failing word address. A missing ack is
//   bounded by TIMEOUT_CYCLES.
//
// Build option:
//   MEMTEST_LOOP_EN  when defined, clean passes repeat back-to-back (no settle
//                    delay), completed passes are counted on loop_count, and a
//                    start pulse during a run stops it at the next CHECK.
//
// Ports:
//   sys_clk, rst           clock, synchronous active-high reset
//   start, mode            run request (accepted in IDLE/DONE), pattern mode
//   initialized            DRAM controller calibration done
//   cyc_o/stb_o/we_o       Wishbone cycle, strobe, write enable
//   addr_o, data_o         byte address, write data
//   data_i, ack_i          read data, transfer acknowledge
//   busy/done/pass/fail    run status
//   timeout                ack timeout occurred
//   err_count              mismatching words (saturating)
//   first_fail_addr        word address of the first mismatch
//   loop_count             completed clean passes (MEMTEST_LOOP_EN only)
// -----------------------------------------------------------------------------
module ddr_memtest_engine
  import memtest_pkg::*;
#(
  parameter int                   WORD_SIZE      = 256,
  parameter int                   ADDR_WIDTH     = 25,
  parameter int                   ADDR_SHIFT     = 7,
  parameter int                   NUM_WORDS      = 1024,
  parameter int                   START_WORD     = 0,
  parameter int                   DELAY_CYCLES   = 100_000_000,
  parameter int                   TIMEOUT_CYCLES = 1_000_000,
  parameter int                   ERR_CNT_WIDTH  = 16,
  parameter logic [WORD_SIZE-1:0] PATTERN        = {16{16'hAABB}}
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic                     initialized,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [BUS_ADDR_W-1:0]    addr_o,
  output logic [WORD_SIZE-1:0]     data_o,
  input  logic [WORD_SIZE-1:0]     data_i,
  input  logic                     ack_i,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    first_fail_addr
`ifdef MEMTEST_LOOP_EN
  ,
  output logic [31:0]              loop_count
`endif
);

  localparam logic [31:0] LAST_IDX = 32'(NUM_WORDS - 1);
  localparam logic [31:0] DLY_LAST = 32'(DELAY_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  memtest_state_t            state_q;
  memtest_mode_t             mode_q;
  logic [31:0]               idx_q;
  logic [31:0]               dly_cnt_q;
  logic [31:0]               tmo_cnt_q;
  logic [WORD_SIZE-1:0]      rdata_q;
  logic                      cyc_q, stb_q, we_q;
  logic [BUS_ADDR_W-1:0]     addr_q;
  logic [WORD_SIZE-1:0]      data_q;
  logic                      busy_q, done_q, pass_q, fail_q, timeout_q;
  logic [ERR_CNT_WIDTH-1:0]  err_q;
  logic [ADDR_WIDTH-1:0]     ffa_q;
`ifdef MEMTEST_LOOP_EN
  logic [31:0]               loop_q;
  logic                      stop_q;
`endif

  // ---------------------------------------------------------------------------
  // Address and pattern datapath
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0]    word_addr_w;
  logic [BUS_ADDR_W-1:0]    byte_addr_w;
  logic [WORD_SIZE-1:0]     pat_w;

  // Both operands are truncated to ADDR_WIDTH, so the sum wraps modulo
  // 2^ADDR_WIDTH without any explicit compare.
  assign word_addr_w = ADDR_WIDTH'(START_WORD) + idx_q[ADDR_WIDTH-1:0];
  assign byte_addr_w = BUS_ADDR_W'(word_addr_w) << ADDR_SHIFT;

  memtest_pattern_gen #(
    .WORD_SIZE  (WORD_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PATTERN    (PATTERN)
  ) u_pattern_gen (
    .mode_i (mode_q),
    .addr_i (word_addr_w),
    .word_o (pat_w)
  );

  // ---------------------------------------------------------------------------
  // Compare, error accounting and end-of-run decision
  // ---------------------------------------------------------------------------
  logic                     mismatch_w;
  logic [ERR_CNT_WIDTH-1:0] err_next_w;
  logic                     last_w;
  logic                     tmo_hit_w;
  logic                     idle_like_w;
  logic                     end_run_w;
  logic                     again_w;

  assign mismatch_w  = (rdata_q != pat_w);
  assign err_next_w  = (mismatch_w && !(&err_q)) ? err_q + 1'b1 : err_q;
  assign last_w      = (idx_q == LAST_IDX);
  assign tmo_hit_w   = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);
  assign idle_like_w = (state_q == S_IDLE) || (state_q == S_DONE);

  // Decided in CHECK: finish the run, restart another pass, or read the next word.
  always_comb begin
    end_run_w = last_w;
    again_w   = 1'b0;
`ifdef MEMTEST_LOOP_EN
    end_run_w = stop_q || (last_w && ((err_next_w != '0) || timeout_q));
    again_w   = last_w && !end_run_w;
`endif
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments only, so every register
  // in this block samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= PAT_FIXED;
      idx_q     <= '0;
      dly_cnt_q <= '0;
      tmo_cnt_q <= '0;
      rdata_q   <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      ffa_q     <= '0;
`ifdef MEMTEST_LOOP_EN
      loop_q    <= '0;
      stop_q    <= 1'b0;
`endif
    end else begin
`ifdef MEMTEST_LOOP_EN
      // A start while running is a stop request, honoured at the next CHECK.
      if (start && !idle_like_w) stop_q <= 1'b1;
`endif
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            ffa_q     <= '0;
            mode_q    <= memtest_mode_t'(mode);
            busy_q    <= 1'b1;
            idx_q     <= '0;
`ifdef MEMTEST_LOOP_EN
            loop_q    <= '0;
            stop_q    <= 1'b0;
`endif
            state_q   <= S_WAIT_INIT;
          end
        end

        S_WAIT_INIT: begin
          if (initialized) begin
            idx_q     <= '0;
            dly_cnt_q <= '0;
            state_q   <= (DELAY_CYCLES == 0) ? S_WRITE : S_DELAY;
          end
        end

        S_DELAY: begin
          if (dly_cnt_q == DLY_LAST) begin
            state_q <= S_WRITE;
          end else begin
            dly_cnt_q <= dly_cnt_q + 1'b1;
          end
        end

        S_WRITE: begin
          cyc_q     <= 1'b1;
          stb_q     <= 1'b1;
          we_q      <= 1'b1;
          addr_q    <= byte_addr_w;
          data_q    <= pat_w;
          tmo_cnt_q <= '0;
          state_q   <= S_WAIT_WRITE;
        end

        S_WAIT_WRITE: begin
          // Ack is tested first so a same-cycle ack beats the timeout.
          if (ack_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            if (last_w) begin
              idx_q   <= '0;
              state_q <= S_READ;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_WRITE;
            end
          end else if (tmo_hit_w) begin
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            timeout_q <= 1'b1;
            fail_q    <= 1'b1;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        S_READ: begin
          cyc_q     <= 1'b1;
          stb_q     <= 1'b1;
          we_q      <= 1'b0;
          addr_q    <= byte_addr_w;
          tmo_cnt_q <= '0;
          state_q   <= S_WAIT_READ;
        end

        S_WAIT_READ: begin
          if (ack_i) begin
            rdata_q <= data_i;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= S_CHECK;
          end else if (tmo_hit_w) begin
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            timeout_q <= 1'b1;
            fail_q    <= 1'b1;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        S_CHECK: begin
          err_q <= err_next_w;
          // The counter saturates and never returns to zero, so zero means
          // no earlier mismatch in this run.
          if (mismatch_w && (err_q == '0)) ffa_q <= word_addr_w;
`ifdef MEMTEST_LOOP_EN
          if (last_w && (err_next_w == '0)) loop_q <= loop_q + 1'b1;
`endif
          if (end_run_w) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_next_w == '0) && !timeout_q;
            fail_q  <= !((err_next_w == '0) && !timeout_q);
            state_q <= S_DONE;
          end else if (again_w) begin
            idx_q   <= '0;
            state_q <= S_WRITE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_READ;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign cyc_o           = cyc_q;
  assign stb_o           = stb_q;
  assign we_o            = we_q;
  assign addr_o          = addr_q;
  assign data_o          = data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail            = fail_q;
  assign timeout         = timeout_q;
  assign err_count       = err_q;
  assign first_fail_addr = ffa_q;
`ifdef MEMTEST_LOOP_EN
  assign loop_count      = loop_q;
`endif

endmodule

// File: tb/tb_ddr_memtest_engine.sv
// -----------------------------------------------------------------------------
// tb_ddr_memtest_engine
//   Self-checking bench for ddr_memtest_engine (default build, single pass).
//   The start word sits two words below the top of the 25-bit word space so
//   every run also crosses the address wrap. A RAM slave with random ack
//   latency answers the bus; a reference model derives the expected bus trace,
//   error count and first-fail address from the pattern rules.
// -----------------------------------------------------------------------------
module tb_ddr_memtest_engine;

  localparam int            WS      = 256;
  localparam int            AW      = 25;
  localparam int            SHIFT   = 7;
  localparam int            NW      = 8;
  localparam int            START   = (1 << 25) - 2;
  localparam int            DLY     = 4;
  localparam int            TMO     = 16;
  localparam int            EW      = 16;
  localparam logic [WS-1:0] PAT     = {16{16'hAABB}};

  logic            sys_clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic            initialized = 1'b1;
  logic            ack_i = 1'b0;
  logic [WS-1:0]   data_i = '0;
  logic            cyc_o, stb_o, we_o;
  logic [31:0]     addr_o;
  logic [WS-1:0]   data_o;
  logic            busy, done, pass, fail, timeout;
  logic [EW-1:0]   err_count;
  logic [AW-1:0]   first_fail_addr;

  always #5 sys_clk = ~sys_clk;

  ddr_memtest_engine #(
    .WORD_SIZE      (WS),
    .ADDR_WIDTH     (AW),
    .ADDR_SHIFT     (SHIFT),
    .NUM_WORDS      (NW),
    .START_WORD     (START),
    .DELAY_CYCLES   (DLY),
    .TIMEOUT_CYCLES (TMO),
    .ERR_CNT_WIDTH  (EW),
    .PATTERN        (PAT)
  ) dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .start           (start),
    .mode            (mode),
    .initialized     (initialized),
    .cyc_o           (cyc_o),
    .stb_o           (stb_o),
    .we_o            (we_o),
    .addr_o          (addr_o),
    .data_o          (data_o),
    .data_i          (data_i),
    .ack_i           (ack_i),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail            (fail),
    .timeout         (timeout),
    .err_count       (err_count),
    .first_fail_addr (first_fail_addr)
  );

  // ---------------------------------------------------------------------------
  // Slave: RAM indexed by the low three word-address bits (the 8 tested words
  // are distinct there), ack after `lat` extra cycles, optional corruption of
  // bit 3 on read-back, optional never-ack.
  // ---------------------------------------------------------------------------
  logic [WS-1:0] mem [8];
  logic [7:0]    corrupt_mask = 8'h00;
  logic          no_ack = 1'b0;
  int            fixed_lat = -1;
  int            lat = 0;
  int            wcnt = 0;

  always @(posedge sys_clk) begin
    if (rst) begin
      ack_i <= 1'b0;
      wcnt  <= 0;
    end else begin
      ack_i <= 1'b0;
      if (cyc_o && stb_o && !ack_i && !no_ack) begin
        if (wcnt >= ((fixed_lat >= 0) ? fixed_lat : lat)) begin
          ack_i <= 1'b1;
          wcnt  <= 0;
          lat   <= int'($urandom_range(0, 3));
          if (we_o) mem[addr_o[9:7]] <= data_o;
          else      data_i <= mem[addr_o[9:7]] ^ (corrupt_mask[addr_o[9:7]] ? 256'h8 : 256'h0);
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: records every acknowledged transfer, flags a missing bus gap after
  // an ack and any change of request signals while a transfer waits.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [WS-1:0] data;
  } xfer_t;

  xfer_t         trace[$];
  int            gap_err = 0;
  int            stable_err = 0;
  logic          prev_ack = 1'b0;
  logic          prev_hold = 1'b0;
  logic          prev_we = 1'b0;
  logic [31:0]   prev_addr = '0;
  logic [WS-1:0] prev_data = '0;

  always @(negedge sys_clk) begin
    if (!rst && cyc_o && stb_o && ack_i)
      trace.push_back('{we: we_o, addr: addr_o, data: data_o});
    if (!rst && prev_ack && cyc_o) gap_err <= gap_err + 1;
    if (!rst && prev_hold && cyc_o && stb_o &&
        (we_o !== prev_we || addr_o !== prev_addr || data_o !== prev_data))
      stable_err <= stable_err + 1;
    prev_ack  <= cyc_o && ack_i;
    prev_hold <= cyc_o && stb_o && !ack_i;
    prev_we   <= we_o;
    prev_addr <= addr_o;
    prev_data <= data_o;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int model_word_addr(input int i);
    return (START + i) % (1 << AW);
  endfunction

  function automatic logic [31:0] model_byte_addr(input int i);
    longint b;
    b = longint'(model_word_addr(i)) * (longint'(1) << SHIFT);
    return 32'(b);
  endfunction

  function automatic logic [WS-1:0] model_pat(input int m, input int a);
    logic [WS-1:0] w;
    w = '0;
    case (m)
      0: w = PAT;
      1: w = (a % 2 == 1) ? ~PAT : PAT;
      2: for (int k = 0; k < WS / 32; k++) w[k*32 +: 32] = 32'(a);
      default: w[a % WS] = 1'b1;
    endcase
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int m);
    @(negedge sys_clk);
    start = 1'b1;
    mode  = 2'(m);
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (done) break;
      @(negedge sys_clk);
    end
    check({tag, " done"}, done, 1'b1);
  endtask

  // One full run: start, optional extra stimulus, then check status and trace.
  task automatic run_and_check(input string tag, input int m, input logic [7:0] mask,
                               input bit poke, input bit init_hold);
    int exp_err;
    int exp_ff;
    int cnt;
    bit seen;
    trace.delete();
    corrupt_mask = mask;
    if (init_hold) initialized = 1'b0;
    pulse_start(m);
    check({tag, " busy"}, busy, 1'b1);
    if (poke) begin
      // A start while busy must be ignored.
      repeat (20) @(negedge sys_clk);
      start = 1'b1;
      mode  = ~2'(m);
      @(negedge sys_clk);
      start = 1'b0;
    end
    if (init_hold) begin
      seen = 1'b0;
      repeat (50) begin
        @(negedge sys_clk);
        if (cyc_o) seen = 1'b1;
      end
      check({tag, " no cyc before init"}, seen, 1'b0);
      initialized = 1'b1;
      cnt = 0;
      while (!cyc_o && cnt < 100) begin
        @(negedge sys_clk);
        if (!cyc_o) cnt++;
      end
      check({tag, " init delay lower"}, cnt >= DLY, 1'b1);
      check({tag, " init delay upper"}, cnt <= DLY + 3, 1'b1);
    end
    wait_done(tag, 2000);
    exp_err = 0;
    exp_ff  = 0;
    for (int i = 0; i < NW; i++) begin
      if (mask[model_word_addr(i) % 8]) begin
        if (exp_err == 0) exp_ff = model_word_addr(i);
        exp_err++;
      end
    end
    check({tag, " err_count"}, err_count, exp_err);
    check({tag, " first_fail"}, first_fail_addr, exp_ff);
    check({tag, " pass"}, pass, exp_err == 0);
    check({tag, " fail"}, fail, exp_err != 0);
    check({tag, " timeout"}, timeout, 1'b0);
    check({tag, " busy end"}, busy, 1'b0);
    check({tag, " xfers"}, trace.size(), 2 * NW);
    for (int i = 0; i < 2 * NW && i < trace.size(); i++) begin
      check($sformatf("%s we[%0d]", tag, i), trace[i].we, i < NW);
      check($sformatf("%s addr[%0d]", tag, i), trace[i].addr, model_byte_addr(i % NW));
      if (i < NW)
        check($sformatf("%s wdata[%0d]", tag, i), trace[i].data, model_pat(m, model_word_addr(i)));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int cnt;
    bit seen;

    // Reset state.
    repeat (3) @(negedge sys_clk);
    check("rst cyc", cyc_o, 1'b0);
    check("rst stb", stb_o, 1'b0);
    check("rst we", we_o, 1'b0);
    check("rst addr", addr_o, '0);
    check("rst data", data_o, '0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst pass", pass, 1'b0);
    check("rst fail", fail, 1'b0);
    check("rst timeout", timeout, 1'b0);
    check("rst err", err_count, '0);
    check("rst ffa", first_fail_addr, '0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("idle busy", busy, 1'b0);

    // Clean mode-0 run with a start pulse injected while busy.
    run_and_check("m0", 0, 8'h00, 1'b1, 1'b0);

    // Corrupted words 2 and 5, address pattern.
    run_and_check("m2err", 2, 8'b0010_0100, 1'b0, 1'b0);

    // Alternating and walking-one patterns, clean.
    run_and_check("m1", 1, 8'h00, 1'b0, 1'b0);
    run_and_check("m3", 3, 8'h00, 1'b0, 1'b0);

    // Random modes and random corruption sets.
    for (int r = 0; r < 4; r++)
      run_and_check($sformatf("rnd%0d", r), int'($urandom_range(0, 3)),
                    8'($urandom_range(0, 255)), 1'b0, 1'b0);

    // initialized held low for 50 cycles after start.
    run_and_check("init", 0, 8'h00, 1'b0, 1'b1);

    // Slave never acks: bus dropped TMO cycles after the strobe rises.
    no_ack = 1'b1;
    trace.delete();
    pulse_start(0);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (stb_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    check("tmo stb seen", seen, 1'b1);
    cnt = 0;
    while (cyc_o && cnt < 100) begin
      @(negedge sys_clk);
      cnt++;
    end
    check("tmo cycles", cnt, TMO);
    check("tmo timeout", timeout, 1'b1);
    check("tmo fail", fail, 1'b1);
    check("tmo pass", pass, 1'b0);
    check("tmo done", done, 1'b1);
    check("tmo busy", busy, 1'b0);
    check("tmo stb", stb_o, 1'b0);
    check("tmo xfers", trace.size(), 0);
    no_ack = 1'b0;

    // Reset while a write waits for its ack.
    fixed_lat = 3;
    pulse_start(0);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (cyc_o && we_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    check("rstmid write seen", seen, 1'b1);
    check("rstmid no ack yet", ack_i, 1'b0);
    rst = 1'b1;
    @(negedge sys_clk);
    check("rstmid cyc", cyc_o, 1'b0);
    check("rstmid stb", stb_o, 1'b0);
    check("rstmid busy", busy, 1'b0);
    check("rstmid done", done, 1'b0);
    rst = 1'b0;
    fixed_lat = -1;
    run_and_check("post_rst", 0, 8'h00, 1'b0, 1'b0);

    // Bus protocol over all runs.
    check("bus gap after ack", gap_err, 0);
    check("bus stable while waiting", stable_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
